// File: rtl/operand_bank.sv
// operand_bank: matrix operand storage with a host read/write port and a sequencer that
// streams A[i][k], B[k][j] pairs in dot-product order. Optional macro: OPBANK_TRANSPOSE_EN.
module operand_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_DIM    = 4,
  parameter int NUM_MAT    = 2,
  localparam int IDX_W     = $clog2(MAX_DIM),
  localparam int DIM_W     = $clog2(MAX_DIM + 1),
  localparam int MSEL_W    = ($clog2(NUM_MAT) > 1) ? $clog2(NUM_MAT) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_en_i,
  input  logic [MSEL_W-1:0]     wr_mat_i,
  input  logic [IDX_W-1:0]      wr_row_i,
  input  logic [IDX_W-1:0]      wr_col_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  wr_drop_o,
  input  logic                  rd_en_i,
  input  logic [MSEL_W-1:0]     rd_mat_i,
  input  logic [IDX_W-1:0]      rd_row_i,
  input  logic [IDX_W-1:0]      rd_col_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  input  logic                  start_i,
  input  logic [DIM_W-1:0]      dim_i,
  input  logic [MSEL_W-1:0]     src_a_i,
  input  logic [MSEL_W-1:0]     src_b_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  str_valid_o,
  input  logic                  str_ready_i,
  output logic [DATA_WIDTH-1:0] str_a_o,
  output logic [DATA_WIDTH-1:0] str_b_o,
  output logic [IDX_W-1:0]      str_i_o,
  output logic [IDX_W-1:0]      str_j_o,
  output logic                  str_last_k_o,
  output logic                  str_last_o
`ifdef OPBANK_TRANSPOSE_EN
  ,
  input  logic                  trans_b_i
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, next_state;

  logic [DATA_WIDTH-1:0] mem [NUM_MAT][MAX_DIM][MAX_DIM];

  logic [MSEL_W-1:0] src_a, src_b;
  logic [IDX_W-1:0]  last_idx, i, j, k;
  logic [IDX_W-1:0]  b_row, b_col;
  logic [DIM_W-1:0]  dim_eff;
  logic              wr_reject, start_ok, beat_ok, last_beat, running;

  assign running   = (state == RUN);
  assign wr_reject = (int'(wr_mat_i) >= NUM_MAT) ||
                     (running && (wr_mat_i == src_a || wr_mat_i == src_b));
  assign start_ok  = (state == IDLE) && start_i && (dim_i != '0);
  assign beat_ok   = running && str_ready_i;
  assign last_beat = (i == last_idx) && (j == last_idx) && (k == last_idx);
  assign dim_eff   = (dim_i > DIM_W'(MAX_DIM)) ? DIM_W'(MAX_DIM) : dim_i;

  // NOTE: storage lives in flops, not a RAM macro, because reset must clear every entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int m = 0; m < NUM_MAT; m++)
        for (int r = 0; r < MAX_DIM; r++)
          for (int c = 0; c < MAX_DIM; c++)
            mem[m][r][c] <= '0;
    end else if (wr_en_i && !wr_reject) begin
      mem[wr_mat_i][wr_row_i][wr_col_i] <= wr_data_i;
    end
  end

  // NOTE: non-blocking assignment samples mem before this edge's write, so a read and
  // write to the same entry in one cycle return the old data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_o  <= '0;
      rd_valid_o <= 1'b0;
      wr_drop_o  <= 1'b0;
    end else begin
      rd_valid_o <= rd_en_i;
      wr_drop_o  <= wr_en_i && wr_reject;
      if (rd_en_i)
        rd_data_o <= (int'(rd_mat_i) >= NUM_MAT) ? '0 : mem[rd_mat_i][rd_row_i][rd_col_i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start_ok) next_state = RUN;
      RUN:     if (beat_ok && last_beat) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Loop indices advance k fastest, then j, then i; wrap after the last beat is harmless.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_a    <= '0;
      src_b    <= '0;
      last_idx <= '0;
      i        <= '0;
      j        <= '0;
      k        <= '0;
    end else if (start_ok) begin
      src_a    <= src_a_i;
      src_b    <= src_b_i;
      last_idx <= IDX_W'(dim_eff - 1'b1);
      i        <= '0;
      j        <= '0;
      k        <= '0;
    end else if (beat_ok) begin
      if (k == last_idx) begin
        k <= '0;
        if (j == last_idx) begin
          j <= '0;
          i <= i + 1'b1;
        end else begin
          j <= j + 1'b1;
        end
      end else begin
        k <= k + 1'b1;
      end
    end
  end

`ifdef OPBANK_TRANSPOSE_EN
  logic trans_b;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       trans_b <= 1'b0;
    else if (start_ok) trans_b <= trans_b_i;
  end

  assign b_row = trans_b ? j : k;
  assign b_col = trans_b ? k : j;
`else
  assign b_row = k;
  assign b_col = j;
`endif

  // Stream outputs are forced to zero outside RUN; hazard protection keeps them stable
  // while the consumer stalls.
  always_comb begin
    busy_o       = running;
    str_valid_o  = running;
    done_o       = (state == DONE);
    str_a_o      = '0;
    str_b_o      = '0;
    str_i_o      = '0;
    str_j_o      = '0;
    str_last_k_o = 1'b0;
    str_last_o   = 1'b0;
    if (running) begin
      if (int'(src_a) < NUM_MAT) str_a_o = mem[src_a][i][k];
      if (int'(src_b) < NUM_MAT) str_b_o = mem[src_b][b_row][b_col];
      str_i_o      = i;
      str_j_o      = j;
      str_last_k_o = (k == last_idx);
      str_last_o   = last_beat;
    end
  end

endmodule

// File: doc/operand_bank.md
# operand_bank

Parametrised operand storage for the matrix-multiply datapath. Holds `NUM_MAT` square matrices of up to `MAX_DIM`×`MAX_DIM` elements, each `DATA_WIDTH` bits wide. A host port writes the matrices and reads them back at random. A sequencer streams operand pairs A[i][k], B[k][j] in dot-product order to the MAC engine over a valid/ready handshake. The block sits between the host load interface and the MAC/accumulator stage.

## Interface
- `DATA_WIDTH`, 32, element width.
- `MAX_DIM`, 4, maximum matrix dimension; ≥2.
- `NUM_MAT`, 2, number of matrices stored; ≥2.
- Derived localparams:
  - `IDX_W` = $clog2(MAX_DIM), row/column index width.
  - `DIM_W` = $clog2(MAX_DIM+1), dimension width.
  - `MSEL_W` = max(1, $clog2(NUM_MAT)), matrix-select width.

Ports:
- `clk_i` in 1: the block's one clock; all state is updated on its rising edge.
- `rst_ni` in 1: asynchronous, active-low reset.
- `wr_en_i` in 1: write strobe.
- `wr_mat_i` in `MSEL_W`, `wr_row_i` in `IDX_W`, `wr_col_i` in `IDX_W`: write address.
- `wr_data_i` in `DATA_WIDTH`: write data.
- `wr_drop_o` out 1: one-cycle pulse when a write is dropped.
- `rd_en_i` in 1: read strobe.
- `rd_mat_i` in `MSEL_W`, `rd_row_i` in `IDX_W`, `rd_col_i` in `IDX_W`: read address.
- `rd_data_o` out `DATA_WIDTH`, `rd_valid_o` out 1: read response.
- `start_i` in 1: start a stream.
- `dim_i` in `DIM_W`: N, sampled on start.
- `src_a_i` in `MSEL_W`, `src_b_i` in `MSEL_W`: source matrices, sampled on start.
- `busy_o` out 1, `done_o` out 1: sequencer status.
- `str_valid_o` in/out: out 1; `str_ready_i` in 1: stream handshake.
- `str_a_o` out `DATA_WIDTH`, `str_b_o` out `DATA_WIDTH`: operand pair.
- `str_i_o` out `IDX_W`, `str_j_o` out `IDX_W`: output-element coordinates.
- `str_last_k_o` out 1: final beat of a dot product.
- `str_last_o` out 1: final beat of the stream.

## Operation
- **Reset:**
  - All storage entries are 0.
  - FSM is IDLE.
  - Every output is 0.
- **Write:**
  - When `wr_en_i` is high, `matrix[wr_mat_i][wr_row_i][wr_col_i]` ← `wr_data_i`.
  - The write is dropped, and `wr_drop_o` pulses, when either:
    - `wr_mat_i` ≥ `NUM_MAT`, or
    - `busy_o`=1 and `wr_mat_i` equals the latched `src_a` or `src_b` (hazard protection).
  - Writes to any other matrix proceed while busy.
- **Read:**
  - When `rd_en_i` is high, `rd_data_o` and `rd_valid_o` are registered one cycle later.
  - `rd_data_o` holds its value while `rd_en_i` is low.
  - If `rd_mat_i` ≥ `NUM_MAT`, the response is 0 with `rd_valid_o`=1.
  - A read and a write to the same entry in the same cycle return the old data.
- **FSM states:**
  - IDLE → RUN on `start_i` when 1 ≤ `dim_i`.
    - On entry, latch N = min(`dim_i`, `MAX_DIM`), `src_a`, `src_b`; set i=j=k=0.
    - `start_i` with `dim_i`=0 is ignored.
  - RUN: stream beats in order `for i, for j, for k`. Each beat presents A[i][k], B[k][j], i, j.
    - `str_last_k_o` = (k==N-1).
    - `str_last_o` = (i==j==k==N-1).
  - RUN → DONE when the last beat is accepted.
  - DONE → IDLE unconditionally. `done_o` is high only in DONE.
- `start_i` in RUN or DONE is ignored.
- **Handshake:**
  - A beat is accepted when `str_valid_o` && `str_ready_i`.
  - While `str_valid_o` && !`str_ready_i`, all `str_*` outputs are held stable.
  - `str_valid_o` never drops without an accepted beat, except on reset.
- **Reset mid-stream:** returns the FSM to IDLE, zeroes all outputs, and clears storage.

## Timing
- `start_i` accepted at edge t: at t+1, `busy_o`=1, `str_valid_o`=1, and the first beat is on the outputs.
- With `str_ready_i` held high: one beat per cycle, N³ beats total.
- Last beat accepted at edge T: at T+1, `str_valid_o`=0, `busy_o`=0, `done_o`=1. At T+2, `done_o`=0 and a new start can be accepted.
- Read latency: 1 cycle. Write is visible to a read issued the next cycle.

## Configuration
- `OPBANK_TRANSPOSE_EN` defined:
  - Adds input `trans_b_i` (1 bit), sampled on start.
  - When latched to 1, the B operand of each beat is B[j][k] instead of B[k][j].
- `OPBANK_TRANSPOSE_EN` undefined:
  - Port absent.
  - B operand is always B[k][j].

## Test plan
- Write then read back:
  - Write 0xDEADBEEF to matrix 1 (row 2, col 3).
  - Read it next cycle → `rd_data_o`=0xDEADBEEF, `rd_valid_o`=1 one cycle after `rd_en_i`.
  - An unwritten entry reads 0 after reset.
- Full stream, ready always high:
  - Setup: N=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], `src_a`=0, `src_b`=1.
  - (a,b) sequence → (1,5),(2,7),(1,6),(2,8),(3,5),(4,7),(3,6),(4,8).
  - `str_last_k_o` on beats 2, 4, 6 and 8; `str_last_o` on beat 8.
  - `done_o` is high the cycle after beat 8.
- Backpressure:
  - Same setup; drop `str_ready_i` for 3 cycles during beat 3.
  - `str_a_o`=1, `str_b_o`=6, `str_i_o`=0, `str_j_o`=1 held stable throughout; sequence otherwise unchanged.
- Hazard:
  - During RUN, write matrix `src_b` → `wr_drop_o` pulses and the entry is unchanged.
  - Write matrix 2 (`NUM_MAT`=3) during RUN → the write succeeds.
- Boundaries:
  - `dim_i`=0 → no busy.
  - `dim_i`=7 with `MAX_DIM`=4 → 64 beats.
  - `start_i` while busy is ignored.
  - Assert `rst_ni` low at beat 5 → all outputs 0 immediately and storage reads 0 afterwards.
- With `OPBANK_TRANSPOSE_EN` and `trans_b_i`=1, using the data above: b sequence → 5,6,7,8,5,6,7,8.
